// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the processor's inter-stage registers: payload and
// control widths for every stage boundary, bit positions inside the ID/EX
// control bundle, and helpers that pack/unpack the ID/EX bundle.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    // IF/ID: instruction 32 + pc+4 32; ctrl carries only a "valid instruction" tag
    localparam int IFID_PAYLOAD_W  = 64;
    localparam int IFID_CTRL_W     = 1;

    // ID/EX: dataA 32 + dataB 32 + pcpp 32 + extendedSignal 32 + write register 4
    localparam int IDEX_PAYLOAD_W  = 132;
    localparam int IDEX_CTRL_W     = 10;

    // EX/MEM: aluResult 32 + dataB 32 + branch target 32 + write register 4
    localparam int EXMEM_PAYLOAD_W = 100;
    localparam int EXMEM_CTRL_W    = 5;

    // MEM/WB: readData 32 + aluResult 32 + write register 4
    localparam int MEMWB_PAYLOAD_W = 68;
    localparam int MEMWB_CTRL_W    = 2;

    // ID/EX control bit positions (ALUOp occupies [4:0])
    localparam int CTRL_ALUOP_LSB  = 0;
    localparam int CTRL_ALUOP_W    = 5;
    localparam int CTRL_ALUSRC     = 5;
    localparam int CTRL_MEMREAD    = 6;
    localparam int CTRL_MEMWRITE   = 7;
    localparam int CTRL_REGWRITE   = 8;
    localparam int CTRL_BRANCH     = 9;

    // ID/EX payload, dataA in the least significant bits
    typedef struct packed {
        logic [3:0]  wr_reg;
        logic [31:0] ext;
        logic [31:0] pcpp;
        logic [31:0] data_b;
        logic [31:0] data_a;
    } idex_payload_t;

    // ID/EX control, ALUOp in the least significant bits
    typedef struct packed {
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic [4:0] alu_op;
    } idex_ctrl_t;

    function automatic logic [IDEX_PAYLOAD_W-1:0] idex_pack_payload(input idex_payload_t p);
        return p;
    endfunction

    function automatic idex_payload_t idex_unpack_payload(input logic [IDEX_PAYLOAD_W-1:0] v);
        return idex_payload_t'(v);
    endfunction

    function automatic logic [IDEX_CTRL_W-1:0] idex_pack_ctrl(input idex_ctrl_t c);
        logic [IDEX_CTRL_W-1:0] v;
        v = '0;
        v[CTRL_ALUOP_LSB +: CTRL_ALUOP_W] = c.alu_op;
        v[CTRL_ALUSRC]                    = c.alu_src;
        v[CTRL_MEMREAD]                   = c.mem_read;
        v[CTRL_MEMWRITE]                  = c.mem_write;
        v[CTRL_REGWRITE]                  = c.reg_write;
        v[CTRL_BRANCH]                    = c.branch;
        return v;
    endfunction

    function automatic idex_ctrl_t idex_unpack_ctrl(input logic [IDEX_CTRL_W-1:0] v);
        idex_ctrl_t c;
        c.alu_op    = v[CTRL_ALUOP_LSB +: CTRL_ALUOP_W];
        c.alu_src   = v[CTRL_ALUSRC];
        c.mem_read  = v[CTRL_MEMREAD];
        c.mem_write = v[CTRL_MEMWRITE];
        c.reg_write = v[CTRL_REGWRITE];
        c.branch    = v[CTRL_BRANCH];
        return c;
    endfunction

    // memToReg has no bit of its own: write-back comes from memory exactly
    // for loads, so it is derived from memRead.
    function automatic logic idex_mem_to_reg(input logic [IDEX_CTRL_W-1:0] v);
        return v[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
// One pipeline entry: valid flag, payload and control bundle. State changes on
// the falling clock edge. clear (priority) empties the entry and zeroes ctrl
// while keeping the payload; load captures a new valid beat.
// Ports:
//   clock, reset_n       falling-edge clock, async active-low reset
//   load, clear          capture d_* / turn into a bubble
//   d_payload, d_ctrl    beat to capture
//   q_valid, q_payload, q_ctrl  registered entry contents
// -----------------------------------------------------------------------------
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = IDEX_PAYLOAD_W,
    parameter int CTRL_W    = IDEX_CTRL_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 clear,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic [CTRL_W-1:0]    d_ctrl,
    output logic                 q_valid,
    output logic [PAYLOAD_W-1:0] q_payload,
    output logic [CTRL_W-1:0]    q_ctrl
);

    logic                 valid_d, valid_q;
    logic [PAYLOAD_W-1:0] payload_d, payload_q;
    logic [CTRL_W-1:0]    ctrl_d, ctrl_q;

    // Next-state: clear beats load; a bubble keeps its stale payload
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        ctrl_d    = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d   = 1'b1;
            payload_d = d_payload;
            ctrl_d    = d_ctrl;
        end else begin
            valid_d   = valid_q;
        end
    end

    // Entry state register, falling edge
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign q_valid   = valid_q;
    assign q_payload = payload_q;
    assign q_ctrl    = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, flush-to-bubble and asynchronous reset. State changes on the falling
// clock edge. Control is forced to zero whenever the stage holds a bubble.
// Ports:
//   clock, reset_n              falling-edge clock, async active-low reset
//   flush                       drop every held beat and the incoming one
//   in_valid/in_ready           upstream handshake
//   in_payload/in_ctrl          upstream beat
//   out_valid/out_ready         downstream handshake
//   out_payload/out_ctrl        main entry contents (ctrl zero on bubble)
//   occupancy                   beats held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = IDEX_PAYLOAD_W,
    parameter int CTRL_W    = IDEX_CTRL_W,
    parameter int SKID      = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [1:0]           occupancy
);

    logic                 main_valid_s;
    logic [PAYLOAD_W-1:0] main_payload_s;
    logic [CTRL_W-1:0]    main_ctrl_s;
    logic                 skid_valid_s;
    logic [PAYLOAD_W-1:0] skid_payload_s;
    logic [CTRL_W-1:0]    skid_ctrl_s;

    logic                 in_ready_s;
    logic                 handshake_s;
    logic                 main_free_s;
    logic                 main_load_s;
    logic                 main_clear_s;
    logic                 main_sel_skid_s;
    logic                 skid_load_s;
    logic                 skid_clear_s;
    logic [PAYLOAD_W-1:0] main_d_payload_s;
    logic [CTRL_W-1:0]    main_d_ctrl_s;

    // Upstream ready: with a skid entry it depends only on registered state,
    // so out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready_s = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else if (SKID != 0) begin
            in_ready_s = ~skid_valid_s;
        end else begin
            in_ready_s = out_ready | ~main_valid_s;
        end
    end

    assign handshake_s = in_valid & in_ready_s;
    assign main_free_s = ~main_valid_s | out_ready;

    // Entry load/clear decisions; flush overrides everything
    always_comb begin
        main_load_s     = 1'b0;
        main_clear_s    = 1'b0;
        main_sel_skid_s = 1'b0;
        skid_load_s     = 1'b0;
        skid_clear_s    = 1'b0;
        if (flush) begin
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            // Main refills from the older skid beat first to keep ordering
            if (main_free_s) begin
                if (skid_valid_s) begin
                    main_load_s     = 1'b1;
                    main_sel_skid_s = 1'b1;
                end else if (handshake_s) begin
                    main_load_s = 1'b1;
                end else begin
                    main_clear_s = 1'b1;
                end
            end else begin
                main_load_s = 1'b0;
            end
            // Skid drains on the first consume; a same-edge handshake refills it
            if (skid_valid_s && main_free_s) begin
                if (handshake_s) begin
                    skid_load_s = 1'b1;
                end else begin
                    skid_clear_s = 1'b1;
                end
            end else if (!main_free_s && handshake_s) begin
                skid_load_s = 1'b1;
            end else begin
                skid_load_s = 1'b0;
            end
        end
    end

    // Source mux for the main entry
    always_comb begin
        main_d_payload_s = in_payload;
        main_d_ctrl_s    = in_ctrl;
        if (main_sel_skid_s) begin
            main_d_payload_s = skid_payload_s;
            main_d_ctrl_s    = skid_ctrl_s;
        end else begin
            main_d_payload_s = in_payload;
            main_d_ctrl_s    = in_ctrl;
        end
    end

    pipe_skid_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W)
    ) u_main_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (main_load_s),
        .clear     (main_clear_s),
        .d_payload (main_d_payload_s),
        .d_ctrl    (main_d_ctrl_s),
        .q_valid   (main_valid_s),
        .q_payload (main_payload_s),
        .q_ctrl    (main_ctrl_s)
    );

    if (SKID != 0) begin : g_skid
        pipe_skid_slot #(
            .PAYLOAD_W (PAYLOAD_W),
            .CTRL_W    (CTRL_W)
        ) u_skid_slot (
            .clock     (clock),
            .reset_n   (reset_n),
            .load      (skid_load_s),
            .clear     (skid_clear_s),
            .d_payload (in_payload),
            .d_ctrl    (in_ctrl),
            .q_valid   (skid_valid_s),
            .q_payload (skid_payload_s),
            .q_ctrl    (skid_ctrl_s)
        );
    end else begin : g_no_skid
        // Without a skid entry the skid controls can never matter
        logic unused_skid_s;
        assign skid_valid_s   = 1'b0;
        assign skid_payload_s = '0;
        assign skid_ctrl_s    = '0;
        assign unused_skid_s  = skid_load_s ^ skid_clear_s;
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = main_valid_s;
    assign out_payload = main_payload_s;
    assign out_ctrl    = main_ctrl_s;
    assign occupancy   = {1'b0, main_valid_s} + {1'b0, skid_valid_s};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives one SKID=0 and one SKID=1 instance from the same stimulus. Each
// instance has a queue of beats it is expected to hold, in acceptance order;
// a monitor compares the DUT against it every cycle and pops on consume.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int PW = 132;
    localparam int CW = 10;
    localparam int BW = PW + CW;

    typedef logic [BW-1:0] beat_t;

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_payload;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input int k, input string nm, input beat_t act, input beat_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL s%0d_%s: got %0h expected %0h", k, nm, act, exp);
        end
    endtask

    // Acceptance rule: a two-entry stage takes a beat while fewer than two are
    // held; a one-entry stage while empty or while its beat leaves this edge.
    function automatic bit model_ready(input int skid, input int held, input bit fl, input bit ordy);
        if (fl) return 1'b0;
        if (skid != 0) return held < 2;
        return (held == 0) || ordy;
    endfunction

    function automatic logic [PW-1:0] rnd_payload();
        logic [PW-1:0] p;
        p = '0;
        for (int w = 0; w < 4; w++) p[w*32 +: 32] = $urandom;
        p[131:128] = 4'($urandom);
        return p;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic          in_ready;
        logic          out_valid;
        logic [PW-1:0] out_payload;
        logic [CW-1:0] out_ctrl;
        logic [1:0]    occupancy;
        beat_t         exp_q[$];
        int            held;

        pipe_stage_reg #(
            .PAYLOAD_W (PW),
            .CTRL_W    (CW),
            .SKID      (k)
        ) u_dut (
            .clock       (clock),
            .reset_n     (reset_n),
            .flush       (flush),
            .in_valid    (in_valid),
            .in_ready    (in_ready),
            .in_payload  (in_payload),
            .in_ctrl     (in_ctrl),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .out_payload (out_payload),
            .out_ctrl    (out_ctrl),
            .occupancy   (occupancy)
        );

        // Monitor: state checks and in-order pop on consume
        always @(posedge clock) begin
            #4;
            held = exp_q.size();
            if (!reset_n) begin
                exp_q.delete();
                held = 0;
                chk(k, "rst_valid", BW'(out_valid), BW'(0));
                chk(k, "rst_occ", BW'(occupancy), BW'(0));
                chk(k, "rst_ctrl", BW'(out_ctrl), BW'(0));
                chk(k, "rst_payload", BW'(out_payload), BW'(0));
                chk(k, "rst_in_ready", BW'(in_ready), BW'(!flush));
            end else begin
                chk(k, "out_valid", BW'(out_valid), BW'(held > 0));
                chk(k, "occupancy", BW'(occupancy), BW'(held));
                chk(k, "in_ready", BW'(in_ready), BW'(model_ready(k, held, flush, out_ready)));
                if (!out_valid) chk(k, "bubble_ctrl", BW'(out_ctrl), BW'(0));
                if (!flush && out_ready && held > 0) begin
                    chk(k, "beat", {out_ctrl, out_payload}, exp_q[0]);
                    exp_q.delete(0);
                end
            end
        end

        // Scoreboard push: record accepted beats, drop everything on flush
        always @(posedge clock) begin
            #5;
            if (reset_n) begin
                if (flush) exp_q.delete();
                else if (in_valid && model_ready(k, held, flush, out_ready))
                    exp_q.push_back({in_ctrl, in_payload});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_payload = '0;
        in_ctrl    = '0;
        out_ready  = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;

        // Bubble: all-ones control with no valid beat must not leak out
        in_ctrl = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            step();
            out_ready = 1'(i % 2);
        end
        step();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_payload = PW'(32'h0BAD);
        step();
        in_valid = 1'b0;
        #1;
        chk(1, "ctrl_live", BW'(g_dut[1].out_ctrl), BW'(10'h3FF));
        chk(0, "ctrl_live", BW'(g_dut[0].out_ctrl), BW'(10'h3FF));
        repeat (2) step();

        // Streaming 1..8 with out_ready=1: one-edge latency
        for (int i = 1; i <= 8; i++) begin
            step();
            in_valid   = 1'b1;
            in_payload = PW'(i);
            in_ctrl    = CW'($urandom);
            if (i >= 2) begin
                #1;
                chk(1, "stream_lat", BW'(g_dut[1].out_payload), BW'(i - 1));
            end
        end
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // Backpressure: A in main, B in skid, C refused until a consume
        step();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = PW'(32'hA);
        step();
        in_payload = PW'(32'hB);
        step();
        in_payload = PW'(32'hC);
        #1;
        chk(1, "full_in_ready", BW'(g_dut[1].in_ready), BW'(0));
        chk(1, "full_occ", BW'(g_dut[1].occupancy), BW'(2));
        step();
        out_ready = 1'b1;
        #1;
        chk(1, "no_comb_ready", BW'(g_dut[1].in_ready), BW'(0));
        step();
        #1;
        chk(1, "ready_after_consume", BW'(g_dut[1].in_ready), BW'(1));
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // Flush with two beats held and a beat on the input
        step();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = rnd_payload();
        in_ctrl    = CW'($urandom);
        step();
        in_payload = rnd_payload();
        step();
        flush      = 1'b1;
        in_payload = rnd_payload();
        in_ctrl    = 10'h3FF;
        step();
        flush      = 1'b0;
        in_payload = rnd_payload();
        #1;
        chk(1, "flush_occ", BW'(g_dut[1].occupancy), BW'(0));
        chk(1, "flush_valid", BW'(g_dut[1].out_valid), BW'(0));
        chk(1, "flush_ctrl", BW'(g_dut[1].out_ctrl), BW'(0));
        chk(0, "flush_occ", BW'(g_dut[0].occupancy), BW'(0));
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk(1, "post_flush_accept", BW'(g_dut[1].occupancy), BW'(1));
        repeat (3) step();

        // SKID=0: combinational out_ready -> in_ready, same-edge replace
        step();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = PW'(32'h50);
        step();
        in_payload = PW'(32'h51);
        #1;
        chk(0, "comb_ready_lo", BW'(g_dut[0].in_ready), BW'(0));
        out_ready = 1'b1;
        #1;
        chk(0, "comb_ready_hi", BW'(g_dut[0].in_ready), BW'(1));
        step();
        in_valid = 1'b0;
        #1;
        chk(0, "comb_same_edge", BW'(g_dut[0].out_payload), BW'(32'h51));
        repeat (2) step();

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            step();
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 19) == 0);
            in_payload = rnd_payload();
            in_ctrl    = CW'($urandom);
        end
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset asserted mid-cycle with the two-entry stage full
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_payload = rnd_payload();
        step();
        in_payload = rnd_payload();
        step();
        in_valid = 1'b0;
        #1;
        chk(1, "pre_rst_occ", BW'(g_dut[1].occupancy), BW'(2));
        #4;
        reset_n = 1'b0;
        #1;
        chk(1, "rst_now_occ", BW'(g_dut[1].occupancy), BW'(0));
        chk(1, "rst_now_valid", BW'(g_dut[1].out_valid), BW'(0));
        chk(1, "rst_now_ctrl", BW'(g_dut[1].out_ctrl), BW'(0));
        chk(0, "rst_now_occ", BW'(g_dut[0].occupancy), BW'(0));
        repeat (2) step();
        reset_n = 1'b1;
        #1;
        chk(1, "rel_in_ready", BW'(g_dut[1].in_ready), BW'(1));
        chk(0, "rel_in_ready", BW'(g_dut[0].in_ready), BW'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid   = 1'b1;
            out_ready  = 1'b1;
            in_payload = rnd_payload();
            in_ctrl    = CW'($urandom);
        end
        step();
        in_valid = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
